// File: rtl/fc_layer_stream.sv
// fc_layer_stream -- streaming fully-connected layer.
//
// Purpose:
//   Accepts INPUT_SIZE signed samples. Each accepted sample is multiplied by
//   one weight per neuron and added into NUM_NEURONS accumulators. After the
//   last sample of a frame, the block adds one bias per neuron (BIAS state).
//   It then drains the neurons one at a time (DRAIN state). Each drained value
//   is rounded half-up, shifted right by FRAC_BITS and saturated to DATA_WIDTH.
//
// Handshake (both ports):
//   A transfer happens on a rising clock edge where valid && ready are both 1.
//   A producer holding valid keeps its payload stable until the transfer.
//   in_ready is 1 only in ACCUM.
//   out_valid is 1 only in DRAIN. While out_ready is low, out_data, out_idx and
//   out_last stay stable.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   in_valid/ready  - input sample handshake, in_data = signed sample
//   weight_addr     - ROM row index (= current input count)
//   weight_row      - combinational ROM row, neuron n at [n*WEIGHT_WIDTH +: WEIGHT_WIDTH]
//   bias_row        - bias per neuron, neuron n at [n*ACC_WIDTH +: ACC_WIDTH]
//   out_valid/ready - output handshake
//   out_data        - requantised result of neuron out_idx
//   out_last        - marks neuron NUM_NEURONS-1
//   dbg_state       - current FSM state (0 ACCUM, 1 BIAS, 2 DRAIN)
//
// Build option:
//   FC_LAYER_STREAM_RELU_EN - when defined, negative results are replaced by
//   0 after saturation. The latency does not change.

module fc_layer_stream #(
   parameter int NUM_NEURONS  = 16,
   parameter int INPUT_SIZE   = 16,
   parameter int DATA_WIDTH   = 16,
   parameter int WEIGHT_WIDTH = 8,
   parameter int ACC_WIDTH    = 32,
   parameter int FRAC_BITS    = 8
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic signed [DATA_WIDTH-1:0]         in_data,
   output logic [$clog2(INPUT_SIZE)-1:0]        weight_addr,
   input  logic [NUM_NEURONS*WEIGHT_WIDTH-1:0]  weight_row,
   input  logic [NUM_NEURONS*ACC_WIDTH-1:0]     bias_row,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic signed [DATA_WIDTH-1:0]         out_data,
   output logic [$clog2(NUM_NEURONS)-1:0]       out_idx,
   output logic                                 out_last,
   output logic [1:0]                           dbg_state
);

   localparam int CW = $clog2(INPUT_SIZE);
   localparam int IW = $clog2(NUM_NEURONS);
   localparam int PW = DATA_WIDTH + WEIGHT_WIDTH;

   localparam logic [CW-1:0] LAST_CNT = CW'(INPUT_SIZE - 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_NEURONS - 1);

   // Requantisation is done one bit wider than the accumulator.
   // Adding the rounding constant therefore can never overflow.
   localparam logic signed [ACC_WIDTH:0] ROUND   = (ACC_WIDTH+1)'(2 ** (FRAC_BITS - 1));
   localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH+1)'((2 ** (DATA_WIDTH - 1)) - 1);
   localparam logic signed [ACC_WIDTH:0] SAT_MIN = (ACC_WIDTH+1)'(-(2 ** (DATA_WIDTH - 1)));

   typedef enum logic [1:0] {
      ST_ACCUM = 2'd0,
      ST_BIAS  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t                      state_q, state_d;
   logic [CW-1:0]               cnt_q, cnt_d;
   logic [IW-1:0]               idx_q, idx_d;
   logic signed [ACC_WIDTH-1:0] acc_q [NUM_NEURONS];
   logic signed [ACC_WIDTH-1:0] acc_d [NUM_NEURONS];

   logic signed [WEIGHT_WIDTH-1:0] w_n      [NUM_NEURONS];
   logic signed [PW-1:0]           prod_n   [NUM_NEURONS];
   logic signed [ACC_WIDTH-1:0]    prod_ext [NUM_NEURONS];
   logic signed [ACC_WIDTH-1:0]    bias_n   [NUM_NEURONS];

   logic signed [ACC_WIDTH-1:0]    sel_acc;
   logic signed [ACC_WIDTH:0]      rnd;
   logic signed [ACC_WIDTH:0]      shifted;
   logic signed [DATA_WIDTH-1:0]   sat_val;
   logic signed [DATA_WIDTH-1:0]   res_val;

   // Per-neuron products and biases, sliced out of the flat row buses.
   // The size casts sign-extend, because the operands are signed.
   always_comb begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
         w_n[n]      = weight_row[n*WEIGHT_WIDTH +: WEIGHT_WIDTH];
         prod_n[n]   = PW'(in_data) * PW'(w_n[n]);
         prod_ext[n] = ACC_WIDTH'(prod_n[n]);
         bias_n[n]   = bias_row[n*ACC_WIDTH +: ACC_WIDTH];
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_ACCUM;
         cnt_q   <= '0;
         idx_q   <= '0;
         for (int n = 0; n < NUM_NEURONS; n++) begin
            acc_q[n] <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         for (int n = 0; n < NUM_NEURONS; n++) begin
            acc_q[n] <= acc_d[n];
         end
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      for (int n = 0; n < NUM_NEURONS; n++) begin
         acc_d[n] = acc_q[n];
      end
      case (state_q)
         ST_ACCUM: begin
            if (in_valid) begin
               for (int n = 0; n < NUM_NEURONS; n++) begin
                  acc_d[n] = acc_q[n] + prod_ext[n];
               end
               if (cnt_q == LAST_CNT) begin
                  cnt_d   = '0;
                  state_d = ST_BIAS;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         ST_BIAS: begin
            for (int n = 0; n < NUM_NEURONS; n++) begin
               acc_d[n] = acc_q[n] + bias_n[n];
            end
            idx_d   = '0;
            state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (out_ready) begin
               if (idx_q == LAST_IDX) begin
                  // Frame done: clear everything so the next frame starts at once.
                  for (int n = 0; n < NUM_NEURONS; n++) begin
                     acc_d[n] = '0;
                  end
                  cnt_d   = '0;
                  idx_d   = '0;
                  state_d = ST_ACCUM;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         default: begin
            state_d = ST_ACCUM;
         end
      endcase
   end

   // Requantise the selected accumulator.
   // The shift is arithmetic and rounds half-up; the result is then saturated.
   always_comb begin
      sel_acc = acc_q[idx_q];
      rnd     = (ACC_WIDTH+1)'(sel_acc) + ROUND;
      shifted = rnd >>> FRAC_BITS;
      if (shifted > SAT_MAX) begin
         sat_val = DATA_WIDTH'(SAT_MAX);
      end else if (shifted < SAT_MIN) begin
         sat_val = DATA_WIDTH'(SAT_MIN);
      end else begin
         sat_val = DATA_WIDTH'(shifted);
      end
`ifdef FC_LAYER_STREAM_RELU_EN
      res_val = sat_val[DATA_WIDTH-1] ? '0 : sat_val;
`else
      res_val = sat_val;
`endif
   end

   // Outputs
   always_comb begin
      in_ready    = (state_q == ST_ACCUM);
      weight_addr = cnt_q;
      out_valid   = (state_q == ST_DRAIN);
      out_idx     = idx_q;
      out_last    = (state_q == ST_DRAIN) && (idx_q == LAST_IDX);
      out_data    = (state_q == ST_DRAIN) ? res_val : '0;
      dbg_state   = state_q;
   end

endmodule

// File: tb/tb_fc_layer_stream.sv
// tb_fc_layer_stream -- bench for fc_layer_stream (4 neurons, 4 inputs).
//
// A frame-level reference model follows the phases of the layer: it counts
// accepted samples, accumulates with plain integer arithmetic, and computes
// the expected requantised results. A single compare process checks the DUT
// outputs against this model on every cycle. Directed frames also pin the
// model's results to hand-computed constants.

module tb_fc_layer_stream;

   localparam int N  = 4;
   localparam int I  = 4;
   localparam int DW = 16;
   localparam int WW = 8;
   localparam int AW = 32;
   localparam int FB = 8;
`ifdef FC_LAYER_STREAM_RELU_EN
   localparam bit RELU = 1'b1;
`else
   localparam bit RELU = 1'b0;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic signed [DW-1:0] in_data = '0;
   logic [1:0]           weight_addr;
   logic [N*WW-1:0]      weight_row;
   logic [N*AW-1:0]      bias_row;
   logic                 out_valid;
   logic                 out_ready = 1'b0;
   logic signed [DW-1:0] out_data;
   logic [1:0]           out_idx;
   logic                 out_last;
   logic [1:0]           dbg_state;

   always #5 clk = ~clk;

   fc_layer_stream #(
      .NUM_NEURONS(N), .INPUT_SIZE(I), .DATA_WIDTH(DW),
      .WEIGHT_WIDTH(WW), .ACC_WIDTH(AW), .FRAC_BITS(FB)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .weight_addr(weight_addr), .weight_row(weight_row), .bias_row(bias_row),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_idx(out_idx), .out_last(out_last), .dbg_state(dbg_state)
   );

   // Weight ROM and bias table
   logic signed [WW-1:0] rom [I][N];
   int                   bias_v [N];

   always_comb begin
      for (int n = 0; n < N; n++) begin
         weight_row[n*WW +: WW] = rom[weight_addr][n];
         bias_row[n*AW +: AW]   = bias_v[n];
      end
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;
   bit chk_on = 1'b0;

   function automatic void chk(input string name, input logic signed [63:0] act,
                               input logic signed [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Expected result of one neuron:
   // round half-up, arithmetic shift, saturate, and optionally clamp negatives to 0.
   function automatic int requant(input int a);
      longint v;
      v = longint'(a) + (longint'(1) << (FB - 1));
      v = v >>> FB;
      if (v > (longint'(1) << (DW - 1)) - 1) v = (longint'(1) << (DW - 1)) - 1;
      if (v < -(longint'(1) << (DW - 1)))    v = -(longint'(1) << (DW - 1));
      if (RELU && v < 0) v = 0;
      return int'(v);
   endfunction

   // Reference model: phase 0 collect, 1 bias, 2 drain
   int m_phase = 0;
   int m_cnt = 0;
   int m_idx = 0;
   int m_frames = 0;
   int m_acc [N];
   int m_exp [N];
   int cyc = 0;
   int t_bias = 0;
   int t_valid = 0;
   bit prev_valid = 1'b0;
   int low_run = 0;
   int last_run = 0;
   logic [DW-1:0] obs_q [$];

   always @(negedge clk) begin
      cyc++;
      if (chk_on && !rst) begin
         chk("in_ready", in_ready, m_phase == 0);
         chk("out_valid", out_valid, m_phase == 2);
         chk("out_last", out_last, (m_phase == 2) && (m_idx == N - 1));
         if (m_phase == 0) chk("weight_addr", weight_addr, m_cnt);
         if (m_phase == 2) begin
            chk("out_idx", out_idx, m_idx);
            chk("out_data", $signed(out_data), m_exp[m_idx]);
         end
      end
      if (out_valid && !prev_valid) t_valid = cyc;
      prev_valid = out_valid;
      if (!in_ready) low_run++;
      else begin
         if (low_run > 0) last_run = low_run;
         low_run = 0;
      end
      // model step for the coming edge
      if (rst) begin
         m_phase = 0; m_cnt = 0; m_idx = 0;
         for (int n = 0; n < N; n++) m_acc[n] = 0;
      end else begin
         case (m_phase)
            0: if (in_valid) begin
               for (int n = 0; n < N; n++) m_acc[n] += int'(in_data) * int'(rom[m_cnt][n]);
               m_cnt++;
               if (m_cnt == I) begin
                  m_cnt = 0; m_phase = 1; t_bias = cyc;
               end
            end
            1: begin
               for (int n = 0; n < N; n++) m_exp[n] = requant(m_acc[n] + bias_v[n]);
               m_idx = 0; m_phase = 2;
            end
            default: if (out_ready) begin
               obs_q.push_back(out_data);
               if (m_idx == N - 1) begin
                  m_phase = 0; m_idx = 0; m_frames++;
                  for (int n = 0; n < N; n++) m_acc[n] = 0;
               end else m_idx++;
            end
         endcase
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_sample(input int d);
      bit ok = 1'b0;
      in_valid = 1'b1;
      in_data  = DW'(d);
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1'b1; break; end
      end
      if (!ok) chk("send_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_frames(input int k);
      int tgt = m_frames + k;
      int t = 0;
      while (m_frames < tgt && t < 2000) begin
         @(negedge clk); t++;
      end
      if (m_frames < tgt) chk("frame_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   task automatic set_tables(input int w, input int b);
      for (int i = 0; i < I; i++)
         for (int n = 0; n < N; n++) rom[i][n] = WW'(w);
      for (int n = 0; n < N; n++) bias_v[n] = b;
   endtask

   task automatic check_obs(input string tag, input int e);
      logic [DW-1:0] v;
      chk({tag, "_count"}, obs_q.size(), N);
      for (int n = 0; n < N; n++) chk({tag, "_pin"}, m_exp[n], e);
      while (obs_q.size() > 0) begin
         v = obs_q.pop_front();
         chk({tag, "_obs"}, $signed(v), e);
      end
   endtask

   task automatic do_frame(input int d, input int w, input int b, input int e, input string tag);
      set_tables(w, b);
      out_ready = 1'b1;
      obs_q.delete();
      repeat (I) send_sample(d);
      wait_frames(1);
      check_obs(tag, e);
   endtask

   task automatic rand_frames(input int nf);
      int tgt = m_frames + nf;
      int last = -1;
      int t = 0;
      while (m_frames < tgt && t < 20000) begin
         if (m_frames != last) begin
            for (int i = 0; i < I; i++)
               for (int n = 0; n < N; n++) rom[i][n] = WW'($urandom);
            for (int n = 0; n < N; n++) bias_v[n] = int'($urandom_range(0, 400000)) - 200000;
            last = m_frames;
         end
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = ($urandom_range(0, 3) == 0) ? DW'($urandom)
                                                 : DW'(int'($urandom_range(0, 4000)) - 2000);
         out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
         t++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      if (m_frames < tgt) chk("rand_timeout", 0, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   initial begin
      set_tables(0, 0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk_on = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_idx", out_idx, 0);
      chk("rst_weight_addr", weight_addr, 0);
      @(posedge clk); #1;

      // Basic frame, plus the latency from the last accepted sample to the first output
      do_frame(256, 1, 0, 4, "basic");
      chk("latency", t_valid - t_bias, 2);

      // Saturation and sign cases
      do_frame(32767, 127, 0, 32767, "sat_pos");
      do_frame(32767, -128, 0, RELU ? 0 : -32768, "sat_neg");
      do_frame(256, -1, 0, RELU ? 0 : -4, "neg_small");
      do_frame(0, 0, 384, 2, "bias_pos");
      do_frame(0, 0, -384, RELU ? 0 : -1, "bias_neg");

      // Output stall at idx 1 while in_valid pulses during DRAIN
      set_tables(1, 0);
      obs_q.delete();
      out_ready = 1'b0;
      repeat (I) send_sample(256);
      for (int k = 0; k < 50 && m_phase != 2; k++) @(negedge clk);
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      repeat (3) begin
         in_valid = 1'($urandom_range(0, 1));
         in_data  = DW'($urandom);
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_frames(1);
      check_obs("stall", 4);
      do_frame(256, 2, 0, 8, "after_stall");

      // Reset in the middle of a frame
      set_tables(1, 0);
      send_sample(256);
      send_sample(256);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      do_frame(256, 1, 0, 4, "after_rst");

      // Two back-to-back frames with in_valid held high
      set_tables(1, 0);
      obs_q.delete();
      out_ready = 1'b1;
      in_data   = DW'(256);
      in_valid  = 1'b1;
      wait_frames(2);
      in_valid = 1'b0;
      @(negedge clk);
      chk("b2b_ready_low", last_run, 1 + N);
      chk("b2b_count", obs_q.size(), 2 * N);
      while (obs_q.size() > 0) chk("b2b_obs", $signed(obs_q.pop_front()), 4);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;

      // Randomised frames checked cycle by cycle against the model
      rand_frames(20);
      repeat (4) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
